// File: rtl/board_pkg.sv
// Shared board-level constants and types for the iCE40 switch conditioning logic.
package board_pkg;

  // System clock rate; the timing defaults below are derived from it.
  localparam int CLK_HZ = 25000000;

  // 10 ms of stable input before a new switch level is accepted.
  localparam int DEBOUNCE_LIMIT_DEFAULT = CLK_HZ / 100;

  // 1 s of continuous hold before a long-press pulse is issued.
  localparam int LONG_LIMIT_DEFAULT = CLK_HZ;

  // Number of push-button switches on the board.
  localparam int NUM_SWITCHES = 4;

  // Accepted (debounced) level of a single switch.
  typedef enum logic {
    LEVEL_LOW  = 1'b0,
    LEVEL_HIGH = 1'b1
  } level_e;

endpackage

// File: rtl/debounce_channel.sv
// Single switch channel: two-flop synchroniser, stable-time debouncer and
// long-press detector, producing a clean level plus press/release/long pulses.
module debounce_channel
  import board_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT,
  parameter int LONG_LIMIT     = LONG_LIMIT_DEFAULT
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Long
);

  localparam int DB_WIDTH   = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int HOLD_WIDTH = $clog2(LONG_LIMIT + 1);

  localparam logic [DB_WIDTH-1:0]   DB_LAST   = DB_WIDTH'(DEBOUNCE_LIMIT - 1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(LONG_LIMIT);

  logic                  sync1;
  logic                  sync2;
  level_e                state;
  level_e                next_state;
  logic [DB_WIDTH-1:0]   db_count;
  logic [DB_WIDTH-1:0]   next_db_count;
  logic [HOLD_WIDTH-1:0] hold_count;
  logic [HOLD_WIDTH-1:0] next_hold_count;
  logic                  long_fired;
  logic                  next_long_fired;
  logic                  press_d;
  logic                  release_d;
  logic                  long_d;

  // Register all channel state; every flop clears on a low reset sample.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      state      <= LEVEL_LOW;
      db_count   <= '0;
      hold_count <= '0;
      long_fired <= 1'b0;
      o_Press    <= 1'b0;
      o_Release  <= 1'b0;
      o_Long     <= 1'b0;
    end else begin
      sync1      <= i_Switch;
      sync2      <= sync1;
      state      <= next_state;
      db_count   <= next_db_count;
      hold_count <= next_hold_count;
      long_fired <= next_long_fired;
      o_Press    <= press_d;
      o_Release  <= release_d;
      o_Long     <= long_d;
    end
  end

  // Next level and counters: any agreeing sample restarts the debounce count,
  // and the hold counter runs only while high and not yet fired, saturating.
  always_comb begin
    next_state      = state;
    next_db_count   = db_count;
    next_hold_count = hold_count;
    next_long_fired = long_fired;

    if (state == level_e'(sync2)) begin
      next_db_count = '0;
    end else if (db_count == DB_LAST) begin
      next_state    = level_e'(sync2);
      next_db_count = '0;
    end else begin
      next_db_count = db_count + 1'b1;
    end

    if (state == LEVEL_LOW) begin
      next_hold_count = '0;
      next_long_fired = 1'b0;
    end else if (!long_fired && (hold_count != HOLD_LAST)) begin
      next_hold_count = hold_count + 1'b1;
      if (next_hold_count == HOLD_LAST) begin
        next_long_fired = 1'b1;
      end
    end
  end

  // Pulse decode, registered so each pulse lines up with the level change.
  always_comb begin
    press_d   = (state == LEVEL_LOW)  && (next_state == LEVEL_HIGH);
    release_d = (state == LEVEL_HIGH) && (next_state == LEVEL_LOW);
    long_d    = (state == LEVEL_HIGH) && !long_fired && (next_hold_count == HOLD_LAST);
  end

  assign o_Switch = (state == LEVEL_HIGH);

endmodule

// File: rtl/switch_debounce.sv
// Conditioning stage for the board's push-button switches: one fully
// independent debounce channel per switch.
module switch_debounce
  import board_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT,
  parameter int LONG_LIMIT     = LONG_LIMIT_DEFAULT
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_SWITCHES-1:0] i_Switch,
  output logic [NUM_SWITCHES-1:0] o_Switch,
  output logic [NUM_SWITCHES-1:0] o_Press,
  output logic [NUM_SWITCHES-1:0] o_Release,
  output logic [NUM_SWITCHES-1:0] o_Long
);

  for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_channel
    debounce_channel #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .LONG_LIMIT     (LONG_LIMIT)
    ) u_channel (
      .i_Clk     (i_Clk),
      .i_Rst_L   (i_Rst_L),
      .i_Switch  (i_Switch[g]),
      .o_Switch  (o_Switch[g]),
      .o_Press   (o_Press[g]),
      .o_Release (o_Release[g]),
      .o_Long    (o_Long[g])
    );
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with short debounce and long-press limits.
module tb_switch_debounce;

  localparam int DEBOUNCE_LIMIT = 4;
  localparam int LONG_LIMIT     = 20;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic [3:0] i_Switch;
  logic [3:0] o_Switch;
  logic [3:0] o_Press;
  logic [3:0] o_Release;
  logic [3:0] o_Long;

  int tests_run    = 0;
  int tests_failed = 0;

  switch_debounce #(
    .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
    .LONG_LIMIT     (LONG_LIMIT)
  ) dut (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .i_Switch  (i_Switch),
    .o_Switch  (o_Switch),
    .o_Press   (o_Press),
    .o_Release (o_Release),
    .o_Long    (o_Long)
  );

  // 25 MHz-style free-running clock (period 10 time units).
  always #5 i_Clk = ~i_Clk;

  // Advance one active edge and settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic test_reset();
    i_Rst_L  = 1'b0;
    i_Switch = 4'b0000;
    tick();
    tick();
    tests_run++;
    if (o_Switch !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_o_Switch got %b expected 0000", o_Switch);
    end
    tests_run++;
    if (o_Press !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_o_Press got %b expected 0000", o_Press);
    end
    tests_run++;
    if (o_Release !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_o_Release got %b expected 0000", o_Release);
    end
    tests_run++;
    if (o_Long !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_o_Long got %b expected 0000", o_Long);
    end
    i_Rst_L = 1'b1;
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_sw;
    logic [3:0] exp_pr;
    logic [3:0] exp_rl;
    i_Switch = 4'b0001;
    for (int k = 0; k <= 6; k++) begin
      tick();
      exp_sw = (k >= 5) ? 4'b0001 : 4'b0000;
      exp_pr = (k == 5) ? 4'b0001 : 4'b0000;
      tests_run++;
      if (o_Switch !== exp_sw) begin
        tests_failed++;
        $display("[TB] FAIL clean_press_level edge=%0d got %b expected %b", k, o_Switch, exp_sw);
      end
      tests_run++;
      if (o_Press !== exp_pr) begin
        tests_failed++;
        $display("[TB] FAIL clean_press_pulse edge=%0d got %b expected %b", k, o_Press, exp_pr);
      end
    end
    i_Switch = 4'b0000;
    for (int k = 0; k <= 6; k++) begin
      tick();
      exp_sw = (k >= 5) ? 4'b0000 : 4'b0001;
      exp_rl = (k == 5) ? 4'b0001 : 4'b0000;
      tests_run++;
      if (o_Switch !== exp_sw) begin
        tests_failed++;
        $display("[TB] FAIL clean_release_level edge=%0d got %b expected %b", k, o_Switch, exp_sw);
      end
      tests_run++;
      if (o_Release !== exp_rl) begin
        tests_failed++;
        $display("[TB] FAIL clean_release_pulse edge=%0d got %b expected %b", k, o_Release, exp_rl);
      end
    end
  endtask

  task automatic test_glitch();
    int activity;
    activity = 0;
    i_Switch = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      if ((o_Switch[1] | o_Press[1] | o_Release[1] | o_Long[1]) !== 1'b0) activity++;
    end
    i_Switch = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      if ((o_Switch[1] | o_Press[1] | o_Release[1] | o_Long[1]) !== 1'b0) activity++;
    end
    tests_run++;
    if (activity != 0) begin
      tests_failed++;
      $display("[TB] FAIL glitch_rejected active_cycles=%0d expected 0", activity);
    end
  endtask

  task automatic test_bounce();
    int presses;
    int releases;
    int longs;
    presses  = 0;
    releases = 0;
    longs    = 0;
    for (int c = 0; c < 20; c++) begin
      i_Switch = (((c / 2) % 2) == 0) ? 4'b0100 : 4'b0000;
      tick();
      if (o_Press[2]) presses++;
      if (o_Release[2]) releases++;
    end
    i_Switch = 4'b0100;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (o_Press[2]) presses++;
      if (o_Release[2]) releases++;
      if (o_Long[2]) longs++;
    end
    tests_run++;
    if (presses != 1) begin
      tests_failed++;
      $display("[TB] FAIL bounce_press_count got %0d expected 1", presses);
    end
    tests_run++;
    if (releases != 0) begin
      tests_failed++;
      $display("[TB] FAIL bounce_release_count got %0d expected 0", releases);
    end
    tests_run++;
    if (o_Switch[2] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bounce_level got %b expected 1", o_Switch[2]);
    end
    i_Switch = 4'b0000;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (o_Release[2]) releases++;
      if (o_Long[2]) longs++;
    end
    tests_run++;
    if (releases != 1 || longs != 0 || o_Switch[2] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bounce_release got releases=%0d longs=%0d level=%b expected 1 0 0",
               releases, longs, o_Switch[2]);
    end
  endtask

  task automatic test_long_press();
    int n;
    int press_edge;
    int long_edge;
    int longs;
    int releases;
    n          = 0;
    press_edge = -1;
    long_edge  = -1;
    longs      = 0;
    releases   = 0;
    i_Switch   = 4'b1000;
    for (int k = 0; k < 10 && press_edge < 0; k++) begin
      tick();
      n++;
      if (o_Press[3]) press_edge = n;
    end
    tests_run++;
    if (press_edge < 0) begin
      tests_failed++;
      $display("[TB] FAIL long_press_seen got none expected press within 10 edges");
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      n++;
      if (o_Long[3]) begin
        longs++;
        if (long_edge < 0) long_edge = n;
      end
    end
    tests_run++;
    if (longs != 1) begin
      tests_failed++;
      $display("[TB] FAIL long_pulse_count got %0d expected 1", longs);
    end
    tests_run++;
    if (long_edge - press_edge != LONG_LIMIT) begin
      tests_failed++;
      $display("[TB] FAIL long_pulse_delay got %0d expected %0d", long_edge - press_edge, LONG_LIMIT);
    end
    i_Switch = 4'b0000;
    for (int k = 0; k <= 7; k++) begin
      tick();
      if (o_Release[3]) releases++;
      tests_run++;
      if (o_Release[3] !== ((k == 5) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("[TB] FAIL long_release_pulse edge=%0d got %b expected %b", k, o_Release[3], (k == 5));
      end
    end
    tests_run++;
    if (releases != 1 || o_Switch[3] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL long_release_final got releases=%0d level=%b expected 1 0", releases, o_Switch[3]);
    end
  endtask

  task automatic test_short_press();
    int presses;
    int releases;
    int longs;
    presses  = 0;
    releases = 0;
    longs    = 0;
    i_Switch = 4'b0001;
    for (int k = 0; k < 10 && presses == 0; k++) begin
      tick();
      if (o_Press[0]) presses++;
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_Press[0]) presses++;
      if (o_Long[0]) longs++;
    end
    i_Switch = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_Press[0]) presses++;
      if (o_Release[0]) releases++;
      if (o_Long[0]) longs++;
    end
    tests_run++;
    if (presses != 1 || releases != 1) begin
      tests_failed++;
      $display("[TB] FAIL short_press_pulses got press=%0d release=%0d expected 1 1", presses, releases);
    end
    tests_run++;
    if (longs != 0) begin
      tests_failed++;
      $display("[TB] FAIL short_press_long got %0d expected 0", longs);
    end
  endtask

  task automatic test_reset_mid_press();
    int presses;
    logic [3:0] exp_sw;
    logic [3:0] exp_pr;
    presses  = 0;
    i_Switch = 4'b0001;
    for (int k = 0; k < 10 && presses == 0; k++) begin
      tick();
      if (o_Press[0]) presses++;
    end
    tick();
    tick();
    tests_run++;
    if (o_Switch !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL midreset_held_level got %b expected 0001", o_Switch);
    end
    i_Rst_L = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests_run++;
      if ({o_Switch, o_Press, o_Release, o_Long} !== 16'h0000) begin
        tests_failed++;
        $display("[TB] FAIL midreset_clear cycle=%0d got %h expected 0000", k,
                 {o_Switch, o_Press, o_Release, o_Long});
      end
    end
    i_Rst_L = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      exp_sw = (k >= 5) ? 4'b0001 : 4'b0000;
      exp_pr = (k == 5) ? 4'b0001 : 4'b0000;
      tests_run++;
      if (o_Switch !== exp_sw || o_Press !== exp_pr) begin
        tests_failed++;
        $display("[TB] FAIL midreset_repress edge=%0d got sw=%b pr=%b expected sw=%b pr=%b",
                 k, o_Switch, o_Press, exp_sw, exp_pr);
      end
    end
    i_Switch = 4'b0000;
    for (int k = 0; k < 8; k++) tick();
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_long_press();
    test_short_press();
    test_reset_mid_press();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
